// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the ALU issue path.
//   alu_txn_t       one queued ALU transaction (mode, cmd, operands, cin, split)
//   issue_state_e   issue FSM states
//   CMD_INC_MUL /
//   CMD_SHL_SUB     MODE=1 commands that take the long result latency
//   is_multi_cycle  true when a mode/cmd pair uses the long latency
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_DATA_WIDTH = 8;
    localparam int ALU_CMD_WIDTH  = 4;

    localparam logic [ALU_CMD_WIDTH-1:0] CMD_INC_MUL = 4'h9;
    localparam logic [ALU_CMD_WIDTH-1:0] CMD_SHL_SUB = 4'hA;

    typedef struct packed {
        logic                      mode;
        logic [ALU_CMD_WIDTH-1:0]  cmd;
        logic [ALU_DATA_WIDTH-1:0] opa;
        logic [ALU_DATA_WIDTH-1:0] opb;
        logic                      cin;
        logic                      split;
    } alu_txn_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_AB,
        SEND_A,
        GAP,
        SEND_B,
        WAIT_RES
    } issue_state_e;

    function automatic logic is_multi_cycle(input logic                     mode,
                                            input logic [ALU_CMD_WIDTH-1:0] cmd);
        return mode && ((cmd == CMD_INC_MUL) || (cmd == CMD_SHL_SUB));
    endfunction

endpackage

// File: rtl/alu_txn_fifo.sv
// ---------------------------------------------------------------------------
// alu_txn_fifo
// Synchronous FIFO of alu_txn_t with a first-word-fall-through read port.
//   CLK, RST   clock, synchronous active-high reset (flushes the FIFO)
//   push       write wr_data (ignored when full)
//   wr_data    transaction to enqueue
//   pop        drop the head entry (ignored when empty)
//   rd_data    current head entry, valid whenever empty=0
//   full/empty occupancy flags
//   count      occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module alu_txn_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       push,
    input  alu_txn_t                   wr_data,
    input  logic                       pop,
    output alu_txn_t                   rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    alu_txn_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and count carry
    // state that matters, and leaving the array unreset lets it map to RAM.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// ---------------------------------------------------------------------------
// alu_issue_queue
// Buffers ALU transactions and drives the ALU input pins one transaction at a
// time, with optional split delivery of OPA and OPB separated by GAP_CYCLES
// idle cycles. res_sample pulses in the cycle the ALU result is stable.
//   CLK, RST                  clock, synchronous active-high reset
//   in_valid / in_ready       upstream handshake (in_ready = FIFO not full)
//   in_mode/in_cmd/in_cin     transaction control fields
//   in_opa/in_opb             operands
//   in_split                  deliver OPA and OPB in separate phases
//   INP_VALID,OPA,OPB,CMD,
//   MODE,CIN,CE               ALU input pins
//   res_sample                one-cycle pulse, ALU outputs valid
//   busy                      FSM not IDLE
//   fifo_count                FIFO occupancy
// BASE_LAT and MUL_LAT must be at least 1; DATA_WIDTH/CMD_WIDTH must match the
// alu_pkg widths because the queued struct is sized by the package.
// ---------------------------------------------------------------------------
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int CMD_WIDTH  = ALU_CMD_WIDTH,
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 3,
    parameter int BASE_LAT   = 1,
    parameter int MUL_LAT    = 3
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_mode,
    input  logic [CMD_WIDTH-1:0]       in_cmd,
    input  logic                       in_cin,
    input  logic [DATA_WIDTH-1:0]      in_opa,
    input  logic [DATA_WIDTH-1:0]      in_opb,
    input  logic                       in_split,
    output logic [1:0]                 INP_VALID,
    output logic [DATA_WIDTH-1:0]      OPA,
    output logic [DATA_WIDTH-1:0]      OPB,
    output logic [CMD_WIDTH-1:0]       CMD,
    output logic                       MODE,
    output logic                       CIN,
    output logic                       CE,
    output logic                       res_sample,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int MAX_LAT = (MUL_LAT > BASE_LAT) ? MUL_LAT : BASE_LAT;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);
    localparam int GAP_W   = 4;

    // Counters are loaded with (latency - 1) so that zero marks the last cycle.
    localparam logic [LAT_W-1:0] BASE_M1 = LAT_W'(BASE_LAT - 1);
    localparam logic [LAT_W-1:0] MUL_M1  = LAT_W'(MUL_LAT - 1);
    localparam logic [GAP_W-1:0] GAP_M1  = GAP_W'(GAP_CYCLES - 1);

    issue_state_e          state;
    alu_txn_t              in_txn;
    alu_txn_t              head;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic [DATA_WIDTH-1:0] opb_q;
    logic [LAT_W-1:0]      lat_cnt;
    logic [LAT_W-1:0]      lat_load;
    logic [GAP_W-1:0]      gap_cnt;

    assign in_txn = '{mode: in_mode, cmd: in_cmd, opa: in_opa, opb: in_opb,
                      cin: in_cin, split: in_split};

    assign in_ready = !full;
    assign busy     = (state != IDLE);
    assign pop      = (state == IDLE) && !empty;

    // Clock enable follows reset directly so it is low for the whole reset.
    assign CE = !RST;

    // MODE/CMD already hold the in-flight transaction when this is used.
    assign lat_load = is_multi_cycle(MODE, CMD) ? MUL_M1 : BASE_M1;

    alu_txn_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push    (in_valid),
        .wr_data (in_txn),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    // State and every ALU-facing output are registered together: each output
    // is written with the value belonging to the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            INP_VALID  <= 2'b00;
            OPA        <= '0;
            OPB        <= '0;
            CMD        <= '0;
            MODE       <= 1'b0;
            CIN        <= 1'b0;
            res_sample <= 1'b0;
            opb_q      <= '0;
            lat_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        OPA   <= head.opa;
                        CMD   <= head.cmd;
                        MODE  <= head.mode;
                        CIN   <= head.cin;
                        opb_q <= head.opb;
                        if (head.split) begin
                            state     <= SEND_A;
                            INP_VALID <= 2'b01;
                        end else begin
                            state     <= ISSUE_AB;
                            INP_VALID <= 2'b11;
                            OPB       <= head.opb;
                        end
                    end
                end

                ISSUE_AB, SEND_B: begin
                    state      <= WAIT_RES;
                    INP_VALID  <= 2'b00;
                    lat_cnt    <= lat_load;
                    res_sample <= (lat_load == '0);
                end

                SEND_A: begin
                    if (GAP_CYCLES == 0) begin
                        state     <= SEND_B;
                        INP_VALID <= 2'b10;
                        OPB       <= opb_q;
                    end else begin
                        state     <= GAP;
                        INP_VALID <= 2'b00;
                        gap_cnt   <= GAP_M1;
                    end
                end

                GAP: begin
                    if (gap_cnt == '0) begin
                        state     <= SEND_B;
                        INP_VALID <= 2'b10;
                        OPB       <= opb_q;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                WAIT_RES: begin
                    if (lat_cnt == '0) begin
                        state      <= IDLE;
                        res_sample <= 1'b0;
                    end else begin
                        lat_cnt    <= lat_cnt - 1'b1;
                        res_sample <= (lat_cnt == LAT_W'(1));
                    end
                end

                default: begin
                    state     <= IDLE;
                    INP_VALID <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_queue
// Scoreboard bench: every accepted transaction is queued with its expected
// fields; a negedge monitor pops it when the DUT issues and tracks the phase
// and result-strobe timing that transaction must follow.
// ---------------------------------------------------------------------------
module tb_alu_issue_queue;
    import alu_pkg::*;

    localparam int DW       = 8;
    localparam int CW       = 4;
    localparam int DEPTH    = 4;
    localparam int GAP      = 3;
    localparam int BASE_LAT = 1;
    localparam int MUL_LAT  = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [CW-1:0] in_cmd;
    logic          in_cin;
    logic [DW-1:0] in_opa;
    logic [DW-1:0] in_opb;
    logic          in_split;
    logic [1:0]    INP_VALID;
    logic [DW-1:0] OPA;
    logic [DW-1:0] OPB;
    logic [CW-1:0] CMD;
    logic          MODE;
    logic          CIN;
    logic          CE;
    logic          res_sample;
    logic          busy;
    logic [2:0]    fifo_count;

    always #5 CLK = ~CLK;

    alu_issue_queue #(
        .DATA_WIDTH (DW),
        .CMD_WIDTH  (CW),
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP),
        .BASE_LAT   (BASE_LAT),
        .MUL_LAT    (MUL_LAT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_cmd     (in_cmd),
        .in_cin     (in_cin),
        .in_opa     (in_opa),
        .in_opb     (in_opb),
        .in_split   (in_split),
        .INP_VALID  (INP_VALID),
        .OPA        (OPA),
        .OPB        (OPB),
        .CMD        (CMD),
        .MODE       (MODE),
        .CIN        (CIN),
        .CE         (CE),
        .res_sample (res_sample),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic alu_txn_t mk(input logic mode, input logic [3:0] cmd,
                                    input logic [7:0] a, input logic [7:0] b,
                                    input logic cin, input logic split);
        alu_txn_t t;
        t.mode  = mode;
        t.cmd   = cmd;
        t.opa   = a;
        t.opb   = b;
        t.cin   = cin;
        t.split = split;
        return t;
    endfunction

    function automatic int ref_lat(input alu_txn_t t);
        return (t.mode && (t.cmd == 4'h9 || t.cmd == 4'hA)) ? MUL_LAT : BASE_LAT;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard and monitor
    // ------------------------------------------------------------------
    alu_txn_t sb[$];
    alu_txn_t cur;
    typedef enum {M_IDLE, M_B, M_RES} mon_e;
    mon_e mon      = M_IDLE;
    logic mon_en   = 1'b0;
    int   cyc      = 0;
    int   exp_b    = 0;
    int   exp_res  = 0;
    int   last_res = -100;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (mon_en) begin
            if (RST) begin
                sb.delete();
                mon = M_IDLE;
                check("ce_in_reset", CE, 1'b0);
            end else begin
                check("ce_active", CE, 1'b1);
                case (mon)
                    M_IDLE: begin
                        check("res_idle", res_sample, 1'b0);
                        if (INP_VALID != 2'b00) begin
                            check("issue_spacing", (cyc - last_res) >= 2, 1'b1);
                            check("sb_nonempty", sb.size() != 0, 1'b1);
                            if (sb.size() != 0) begin
                                cur = sb.pop_front();
                                check("issue_opa", OPA, cur.opa);
                                check("issue_cmd", CMD, cur.cmd);
                                check("issue_mode", MODE, cur.mode);
                                check("issue_cin", CIN, cur.cin);
                                if (cur.split) begin
                                    check("phase_a", INP_VALID, 2'b01);
                                    exp_b = cyc + GAP + 1;
                                    mon   = M_B;
                                end else begin
                                    check("phase_ab", INP_VALID, 2'b11);
                                    check("issue_opb", OPB, cur.opb);
                                    exp_res = cyc + ref_lat(cur);
                                    mon     = M_RES;
                                end
                            end
                        end
                    end
                    M_B: begin
                        check("res_in_gap", res_sample, 1'b0);
                        if (cyc < exp_b) begin
                            check("gap_inp_valid", INP_VALID, 2'b00);
                        end else begin
                            check("phase_b", INP_VALID, 2'b10);
                            check("b_opb", OPB, cur.opb);
                            check("b_opa_hold", OPA, cur.opa);
                            check("b_cmd_hold", CMD, cur.cmd);
                            check("b_mode_hold", MODE, cur.mode);
                            exp_res = cyc + ref_lat(cur);
                            mon     = M_RES;
                        end
                    end
                    M_RES: begin
                        check("wait_inp_valid", INP_VALID, 2'b00);
                        if (cyc < exp_res) begin
                            check("res_early", res_sample, 1'b0);
                        end else begin
                            check("res_sample", res_sample, 1'b1);
                            check("res_opa_hold", OPA, cur.opa);
                            check("res_opb_hold", OPB, cur.opb);
                            last_res = cyc;
                            mon      = M_IDLE;
                        end
                    end
                    default: mon = M_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic send(input alu_txn_t t);
        @(negedge CLK);
        in_valid = 1'b1;
        in_mode  = t.mode;
        in_cmd   = t.cmd;
        in_opa   = t.opa;
        in_opb   = t.opb;
        in_cin   = t.cin;
        in_split = t.split;
        for (int w = 0; w < 60; w++) begin
            if (in_ready) begin
                sb.push_back(t);
                @(posedge CLK);
                #1 in_valid = 1'b0;
                return;
            end
            @(negedge CLK);
        end
        check("accept_timeout", in_ready, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int w = 0; w < 300; w++) begin
            @(negedge CLK);
            if (sb.size() == 0 && mon == M_IDLE && !busy) break;
        end
        check("drain_sb_empty", sb.size(), 0);
        check("drain_not_busy", busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        RST      = 1'b1;
        in_valid = 1'b0;
        in_mode  = 1'b0;
        in_cmd   = '0;
        in_cin   = 1'b0;
        in_opa   = '0;
        in_opb   = '0;
        in_split = 1'b0;

        repeat (3) @(negedge CLK);
        check("rst_inp_valid", INP_VALID, 2'b00);
        check("rst_opa", OPA, 8'h00);
        check("rst_opb", OPB, 8'h00);
        check("rst_cmd", CMD, 4'h0);
        check("rst_mode", MODE, 1'b0);
        check("rst_cin", CIN, 1'b0);
        check("rst_ce", CE, 1'b0);
        check("rst_res", res_sample, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fifo_count, 3'd0);

        RST    = 1'b0;
        mon_en = 1'b1;
        @(negedge CLK);
        check("post_rst_ready", in_ready, 1'b1);

        // Non-split ADD: issue two cycles after the push edge, result one later.
        send(mk(1'b1, 4'h0, 8'h0F, 8'h01, 1'b0, 1'b0));
        @(negedge CLK);
        check("add_t1_inp_valid", INP_VALID, 2'b00);
        @(negedge CLK);
        check("add_t2_inp_valid", INP_VALID, 2'b11);
        @(negedge CLK);
        check("add_res_t3", res_sample, 1'b1);
        drain();

        // Split AND with a 3-cycle gap.
        send(mk(1'b0, 4'h0, 8'hF0, 8'h3C, 1'b0, 1'b1));
        drain();

        // Multiply followed immediately by another transaction.
        send(mk(1'b1, 4'h9, 8'h02, 8'h03, 1'b0, 1'b0));
        send(mk(1'b1, 4'h0, 8'h11, 8'h22, 1'b1, 1'b0));
        drain();

        // Other long-latency command, and cmd 9 in logic mode (short latency).
        send(mk(1'b1, 4'hA, 8'h80, 8'h01, 1'b1, 1'b1));
        send(mk(1'b0, 4'h9, 8'h55, 8'hAA, 1'b1, 1'b0));
        drain();

        // Fill: the first split keeps the FSM busy while four more queue up.
        send(mk(1'b0, 4'h1, 8'hA1, 8'hB1, 1'b0, 1'b1));
        send(mk(1'b1, 4'h2, 8'hA2, 8'hB2, 1'b0, 1'b0));
        send(mk(1'b1, 4'h9, 8'hA3, 8'hB3, 1'b1, 1'b0));
        send(mk(1'b0, 4'h3, 8'hA4, 8'hB4, 1'b0, 1'b1));
        send(mk(1'b1, 4'h5, 8'hA5, 8'hB5, 1'b1, 1'b0));
        @(negedge CLK);
        check("full_count", fifo_count, 3'd4);
        check("full_ready", in_ready, 1'b0);
        send(mk(1'b1, 4'hA, 8'hA6, 8'hB6, 1'b0, 1'b0));
        drain();

        // Random mix.
        for (int i = 0; i < 10; i++) begin
            send(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
        end
        drain();

        // Reset during the gap of a split transaction with another queued.
        send(mk(1'b1, 4'h9, 8'hC0, 8'hC1, 1'b0, 1'b1));
        send(mk(1'b1, 4'h0, 8'hD0, 8'hD1, 1'b0, 1'b0));
        begin : wait_phase_a
            for (int w = 0; w < 30; w++) begin
                if (INP_VALID == 2'b01) disable wait_phase_a;
                @(negedge CLK);
            end
        end
        check("saw_phase_a", INP_VALID, 2'b01);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_inp_valid", INP_VALID, 2'b00);
        check("midrst_count", fifo_count, 3'd0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_res", res_sample, 1'b0);
        check("midrst_ce", CE, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (8) @(negedge CLK);
        check("post_midrst_idle", busy, 1'b0);

        // Recovery after reset.
        send(mk(1'b1, 4'h9, 8'h07, 8'h06, 1'b1, 1'b0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
